// File: rtl/amba_axi_pkg.sv
// Shared AXI / AXI-Lite definitions for the bus bridge blocks.
// Holds bus widths, burst and response encodings, the slave-side and
// master-side channel bundles, and the burst-splitter FSM state types.
package amba_axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_USER_W = 1;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
    typedef logic [AXI_DATA_W-1:0] axi_data_t;
    typedef logic [AXI_STRB_W-1:0] axi_strb_t;
    typedef logic [AXI_ID_W-1:0]   axi_id_t;
    typedef logic [AXI_USER_W-1:0] axi_user_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axi_burst_t;

    // Encoding order doubles as severity order for response merging.
    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    // Full-AXI requests arriving at a slave port.
    typedef struct packed {
        axi_id_t    awid;
        axi_addr_t  awaddr;
        logic [7:0] awlen;
        logic [2:0] awsize;
        axi_burst_t awburst;
        logic [2:0] awprot;
        logic       awvalid;
        axi_data_t  wdata;
        axi_strb_t  wstrb;
        logic       wlast;
        logic       wvalid;
        logic       bready;
        axi_id_t    arid;
        axi_addr_t  araddr;
        logic [7:0] arlen;
        logic [2:0] arsize;
        axi_burst_t arburst;
        logic [2:0] arprot;
        logic       arvalid;
        logic       rready;
    } s_axi_mosi_t;

    // Full-AXI responses leaving a slave port.
    typedef struct packed {
        logic      awready;
        logic      wready;
        axi_id_t   bid;
        axi_resp_t bresp;
        axi_user_t buser;
        logic      bvalid;
        logic      arready;
        axi_id_t   rid;
        axi_data_t rdata;
        axi_resp_t rresp;
        logic      rlast;
        axi_user_t ruser;
        logic      rvalid;
    } s_axi_miso_t;

    // AXI-Lite requests driven toward a downstream slave.
    typedef struct packed {
        axi_id_t   awid;
        axi_addr_t awaddr;
        logic [2:0] awprot;
        logic      awvalid;
        axi_data_t wdata;
        axi_strb_t wstrb;
        logic      wvalid;
        logic      bready;
        axi_id_t   arid;
        axi_addr_t araddr;
        logic [2:0] arprot;
        logic      arvalid;
        logic      rready;
    } s_axil_mosi_t;

    // AXI-Lite responses returned by the downstream slave.
    typedef struct packed {
        logic      awready;
        logic      wready;
        axi_resp_t bresp;
        logic      bvalid;
        logic      arready;
        axi_data_t rdata;
        axi_resp_t rresp;
        logic      rvalid;
    } s_axil_miso_t;

    typedef enum logic [1:0] {W_IDLE, W_BEAT, W_BRESP, W_DONE} axi2axil_wr_st_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA}          axi2axil_rd_st_t;

    // Worst-of merge: the numerically larger response code wins.
    function automatic axi_resp_t resp_merge(input axi_resp_t a, input axi_resp_t b);
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Next-beat address generator for one AXI burst.
// Ports:
//   addr      - address of the current beat
//   size      - beat size code; byte step is 1 << size
//   len       - burst length minus one
//   burst     - FIXED / INCR / WRAP (reserved code behaves as INCR)
//   next_addr - address of the following beat (purely combinational)
module axi_addr_gen
    import amba_axi_pkg::*;
(
    input  axi_addr_t  addr,
    input  logic [2:0] size,
    input  logic [7:0] len,
    input  axi_burst_t burst,
    output axi_addr_t  next_addr
);

    axi_addr_t step;
    axi_addr_t incr_addr;
    axi_addr_t wrap_mask;

    always_comb begin
        step      = axi_addr_t'(1) << size;
        incr_addr = addr + step;
        // Wrap window is (len+1)*step bytes; its base is addr with the
        // window-offset bits cleared.
        wrap_mask = ((axi_addr_t'(len) + axi_addr_t'(1)) << size) - axi_addr_t'(1);
        case (burst)
            AXI_BURST_FIXED: next_addr = addr;
            AXI_BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:         next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_burst_to_axil.sv
// Full-AXI slave to AXI-Lite master bridge. Each burst is split into
// len+1 single AXI-Lite transfers, issued one at a time. The write and
// read paths are independent FSMs and may run concurrently.
// Ports:
//   clk, rst     - clock and asynchronous active-low reset
//   axi_mosi_i   - full-AXI requests (AW, W, AR, bready, rready)
//   axi_miso_o   - full-AXI responses (ready signals, B, R)
//   axil_mosi_o  - AXI-Lite requests toward the downstream slave
//   axil_miso_i  - AXI-Lite responses from the downstream slave
module axi_burst_to_axil
    import amba_axi_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  s_axi_mosi_t  axi_mosi_i,
    output s_axi_miso_t  axi_miso_o,
    output s_axil_mosi_t axil_mosi_o,
    input  s_axil_miso_t axil_miso_i
);

    // ---------------- write path ----------------
    axi2axil_wr_st_t wr_st, wr_st_nxt;
    axi_id_t    aw_id;
    axi_addr_t  aw_addr, aw_addr_nxt;
    logic [7:0] aw_len, w_cnt;
    logic [2:0] aw_size, aw_prot;
    axi_burst_t aw_burst;
    axi_resp_t  w_resp_acc;
    logic       aw_done, w_done;
    logic       w_awready, w_wready, w_bvalid, l_awvalid, l_wvalid, l_bready;

    // ---------------- read path ----------------
    axi2axil_rd_st_t rd_st, rd_st_nxt;
    axi_id_t    ar_id;
    axi_addr_t  ar_addr, ar_addr_nxt;
    logic [7:0] ar_len, r_cnt;
    logic [2:0] ar_size, ar_prot;
    axi_burst_t ar_burst;
    logic       r_arready, r_rvalid, r_last, l_arvalid, l_rready;

    logic unused_inputs;
    assign unused_inputs = axi_mosi_i.wlast;

    axi_addr_gen u_wr_addr_gen (
        .addr (aw_addr), .size (aw_size), .len (aw_len), .burst (aw_burst), .next_addr (aw_addr_nxt)
    );
    axi_addr_gen u_rd_addr_gen (
        .addr (ar_addr), .size (ar_size), .len (ar_len), .burst (ar_burst), .next_addr (ar_addr_nxt)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_st <= W_IDLE;
            rd_st <= R_IDLE;
        end else begin
            wr_st <= wr_st_nxt;
            rd_st <= rd_st_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned, which would infer a latch.
        wr_st_nxt = wr_st;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        l_awvalid = 1'b0;
        l_wvalid  = 1'b0;
        l_bready  = 1'b0;
        case (wr_st)
            W_IDLE: begin
                // Gated with rst so awready stays low while reset is held.
                w_awready = rst;
                if (rst && axi_mosi_i.awvalid) wr_st_nxt = W_BEAT;
            end
            W_BEAT: begin
                l_awvalid = !aw_done;
                l_wvalid  = axi_mosi_i.wvalid && !w_done;
                w_wready  = axil_miso_i.wready && !w_done;
                if ((aw_done || axil_miso_i.awready) &&
                    (w_done || (axi_mosi_i.wvalid && axil_miso_i.wready)))
                    wr_st_nxt = W_BRESP;
            end
            W_BRESP: begin
                l_bready = 1'b1;
                if (axil_miso_i.bvalid) wr_st_nxt = (w_cnt == aw_len) ? W_DONE : W_BEAT;
            end
            W_DONE: begin
                w_bvalid = 1'b1;
                if (axi_mosi_i.bready) wr_st_nxt = W_IDLE;
            end
            default: wr_st_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_id      <= '0;
            aw_addr    <= '0;
            aw_len     <= '0;
            aw_size    <= '0;
            aw_burst   <= AXI_BURST_FIXED;
            aw_prot    <= '0;
            w_cnt      <= '0;
            w_resp_acc <= AXI_RESP_OKAY;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            case (wr_st)
                W_IDLE: if (w_awready && axi_mosi_i.awvalid) begin
                    aw_id      <= axi_mosi_i.awid;
                    aw_addr    <= axi_mosi_i.awaddr;
                    aw_len     <= axi_mosi_i.awlen;
                    aw_size    <= axi_mosi_i.awsize;
                    aw_burst   <= axi_mosi_i.awburst;
                    aw_prot    <= axi_mosi_i.awprot;
                    w_cnt      <= '0;
                    w_resp_acc <= AXI_RESP_OKAY;
                    aw_done    <= 1'b0;
                    w_done     <= 1'b0;
                end
                W_BEAT: begin
                    if (wr_st_nxt == W_BRESP) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        if (l_awvalid && axil_miso_i.awready) aw_done <= 1'b1;
                        if (l_wvalid && axil_miso_i.wready)   w_done  <= 1'b1;
                    end
                end
                W_BRESP: if (axil_miso_i.bvalid) begin
                    w_resp_acc <= resp_merge(w_resp_acc, axil_miso_i.bresp);
                    if (w_cnt != aw_len) begin
                        aw_addr <= aw_addr_nxt;
                        w_cnt   <= w_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign r_last = (r_cnt == ar_len);

    always_comb begin
        rd_st_nxt = rd_st;
        r_arready = 1'b0;
        r_rvalid  = 1'b0;
        l_arvalid = 1'b0;
        l_rready  = 1'b0;
        case (rd_st)
            R_IDLE: begin
                r_arready = rst;
                if (rst && axi_mosi_i.arvalid) rd_st_nxt = R_ADDR;
            end
            R_ADDR: begin
                l_arvalid = 1'b1;
                if (axil_miso_i.arready) rd_st_nxt = R_DATA;
            end
            R_DATA: begin
                r_rvalid = axil_miso_i.rvalid;
                l_rready = axi_mosi_i.rready;
                if (axil_miso_i.rvalid && axi_mosi_i.rready)
                    rd_st_nxt = r_last ? R_IDLE : R_ADDR;
            end
            default: rd_st_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ar_id    <= '0;
            ar_addr  <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
            ar_burst <= AXI_BURST_FIXED;
            ar_prot  <= '0;
            r_cnt    <= '0;
        end else begin
            case (rd_st)
                R_IDLE: if (r_arready && axi_mosi_i.arvalid) begin
                    ar_id    <= axi_mosi_i.arid;
                    ar_addr  <= axi_mosi_i.araddr;
                    ar_len   <= axi_mosi_i.arlen;
                    ar_size  <= axi_mosi_i.arsize;
                    ar_burst <= axi_mosi_i.arburst;
                    ar_prot  <= axi_mosi_i.arprot;
                    r_cnt    <= '0;
                end
                R_DATA: if (axil_miso_i.rvalid && axi_mosi_i.rready && !r_last) begin
                    ar_addr <= ar_addr_nxt;
                    r_cnt   <= r_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Output bundles: unused fields (buser/ruser included) stay zero.
    always_comb begin
        axi_miso_o  = '0;
        axil_mosi_o = '0;

        axi_miso_o.awready  = w_awready;
        axi_miso_o.wready   = w_wready;
        axi_miso_o.bid      = aw_id;
        axi_miso_o.bresp    = w_resp_acc;
        axi_miso_o.bvalid   = w_bvalid;
        axi_miso_o.arready  = r_arready;
        axi_miso_o.rid      = ar_id;
        axi_miso_o.rdata    = axil_miso_i.rdata;
        axi_miso_o.rresp    = axil_miso_i.rresp;
        axi_miso_o.rlast    = r_last;
        axi_miso_o.rvalid   = r_rvalid;

        axil_mosi_o.awid    = aw_id;
        axil_mosi_o.awaddr  = aw_addr;
        axil_mosi_o.awprot  = aw_prot;
        axil_mosi_o.awvalid = l_awvalid;
        axil_mosi_o.wdata   = axi_mosi_i.wdata;
        axil_mosi_o.wstrb   = axi_mosi_i.wstrb;
        axil_mosi_o.wvalid  = l_wvalid;
        axil_mosi_o.bready  = l_bready;
        axil_mosi_o.arid    = ar_id;
        axil_mosi_o.araddr  = ar_addr;
        axil_mosi_o.arprot  = ar_prot;
        axil_mosi_o.arvalid = l_arvalid;
        axil_mosi_o.rready  = l_rready;
    end

endmodule

// File: tb/tb_axi_burst_to_axil.sv
// Scoreboard bench for axi_burst_to_axil. Stimulus pushes the expected
// AXI-Lite transfers and full-AXI responses into queues; a monitor pops
// and compares on each handshake. A small downstream AXI-Lite slave model
// answers reads with addr ^ 32'hA5A5_0000 and writes with planned bresp.
module tb_axi_burst_to_axil;
    import amba_axi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    s_axi_mosi_t  mosi;
    s_axi_miso_t  miso;
    s_axil_mosi_t lmosi;
    s_axil_miso_t lmiso;

    axi_burst_to_axil dut (
        .clk         (clk),
        .rst         (rst),
        .axi_mosi_i  (mosi),
        .axi_miso_o  (miso),
        .axil_mosi_o (lmosi),
        .axil_miso_i (lmiso)
    );

    typedef struct { axi_addr_t addr; axi_id_t id; } exp_a_t;
    typedef struct { axi_id_t id; axi_resp_t resp; } exp_b_t;
    typedef struct { axi_id_t id; axi_data_t data; logic last; } exp_r_t;

    exp_a_t    exp_aw_q[$];
    exp_a_t    exp_ar_q[$];
    axi_data_t exp_w_q[$];
    exp_b_t    exp_b_q[$];
    exp_r_t    exp_r_q[$];
    axi_resp_t slv_bresp_q[$];

    int errors = 0;
    int checks = 0;
    int mon_aw_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an unexpected transfer, expected none", name);
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic exp_aw(input axi_id_t id, input axi_addr_t a);
        exp_a_t e; e.addr = a; e.id = id; exp_aw_q.push_back(e);
    endtask
    task automatic exp_ar(input axi_id_t id, input axi_addr_t a);
        exp_a_t e; e.addr = a; e.id = id; exp_ar_q.push_back(e);
    endtask
    task automatic exp_b(input axi_id_t id, input axi_resp_t r);
        exp_b_t e; e.id = id; e.resp = r; exp_b_q.push_back(e);
    endtask
    task automatic exp_r(input axi_id_t id, input axi_data_t d, input logic last);
        exp_r_t e; e.id = id; e.data = d; e.last = last; exp_r_q.push_back(e);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_a_t ea;
        exp_b_t eb;
        exp_r_t er;
        axi_data_t ew;
        if (rst) begin
            if (lmosi.awvalid && lmiso.awready) begin
                mon_aw_n++;
                if (exp_aw_q.size() == 0) unexpected("axil_aw");
                else begin
                    ea = exp_aw_q.pop_front();
                    check("axil_awaddr", lmosi.awaddr, ea.addr);
                    check("axil_awid", lmosi.awid, ea.id);
                end
            end
            if (lmosi.wvalid && lmiso.wready) begin
                if (exp_w_q.size() == 0) unexpected("axil_w");
                else begin
                    ew = exp_w_q.pop_front();
                    check("axil_wdata", lmosi.wdata, ew);
                end
            end
            if (lmosi.arvalid && lmiso.arready) begin
                if (exp_ar_q.size() == 0) unexpected("axil_ar");
                else begin
                    ea = exp_ar_q.pop_front();
                    check("axil_araddr", lmosi.araddr, ea.addr);
                    check("axil_arid", lmosi.arid, ea.id);
                end
            end
            if (miso.bvalid && mosi.bready) begin
                if (exp_b_q.size() == 0) unexpected("axi_b");
                else begin
                    eb = exp_b_q.pop_front();
                    check("axi_bid", miso.bid, eb.id);
                    check("axi_bresp", miso.bresp, eb.resp);
                    check("axi_buser", miso.buser, 0);
                end
            end
            if (miso.rvalid && mosi.rready) begin
                if (exp_r_q.size() == 0) unexpected("axi_r");
                else begin
                    er = exp_r_q.pop_front();
                    check("axi_rdata", miso.rdata, er.data);
                    check("axi_rlast", miso.rlast, er.last);
                    check("axi_rid", miso.rid, er.id);
                end
            end
        end
    end

    // ---------------- downstream AXI-Lite slave model ----------------
    initial begin
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w;
        axi_addr_t ar_a;
        got_aw = 1'b0;
        got_w  = 1'b0;
        lmiso = '0;
        lmiso.awready = 1'b1;
        lmiso.arready = 1'b1;
        lmiso.wready  = 1'b1;
        forever begin
            @(negedge clk);
            aw_hs = lmosi.awvalid && lmiso.awready;
            w_hs  = lmosi.wvalid && lmiso.wready;
            b_hs  = lmiso.bvalid && lmosi.bready;
            ar_hs = lmosi.arvalid && lmiso.arready;
            r_hs  = lmiso.rvalid && lmosi.rready;
            ar_a  = lmosi.araddr;
            @(posedge clk);
            #1;
            if (!rst) begin
                got_aw = 1'b0;
                got_w  = 1'b0;
                lmiso.bvalid = 1'b0;
                lmiso.rvalid = 1'b0;
                lmiso.wready = 1'b1;
            end else begin
                if (aw_hs) got_aw = 1'b1;
                if (w_hs)  got_w  = 1'b1;
                if (b_hs)  lmiso.bvalid = 1'b0;
                if (got_aw && got_w && !lmiso.bvalid) begin
                    lmiso.bvalid = 1'b1;
                    lmiso.bresp  = (slv_bresp_q.size() != 0) ? slv_bresp_q.pop_front() : AXI_RESP_OKAY;
                    got_aw = 1'b0;
                    got_w  = 1'b0;
                end
                // Alternate wready so AW and W handshakes land in different cycles.
                lmiso.wready = ~lmiso.wready;
                if (r_hs) lmiso.rvalid = 1'b0;
                if (ar_hs) begin
                    lmiso.rvalid = 1'b1;
                    lmiso.rdata  = ar_a ^ 32'hA5A5_0000;
                    lmiso.rresp  = AXI_RESP_OKAY;
                end
            end
        end
    end

    // ---------------- full-AXI master drivers ----------------
    task automatic axi_write(input axi_id_t id, input axi_addr_t addr, input logic [7:0] len,
                             input logic [2:0] size, input axi_burst_t burst, input axi_data_t base);
        bit ok;
        @(posedge clk); #1;
        mosi.awid = id; mosi.awaddr = addr; mosi.awlen = len; mosi.awsize = size;
        mosi.awburst = burst; mosi.awprot = 3'b010; mosi.awvalid = 1'b1;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (miso.awready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        mosi.awvalid = 1'b0;
        if (!ok) begin timeout("axi_aw"); return; end
        for (int i = 0; i <= int'(len); i++) begin
            mosi.wvalid = 1'b1;
            mosi.wdata  = base + axi_data_t'(i);
            mosi.wlast  = (i == int'(len));
            ok = 0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (miso.wready) begin ok = 1; break; end
            end
            @(posedge clk); #1;
            if (!ok) begin mosi.wvalid = 1'b0; timeout("axi_w"); return; end
        end
        mosi.wvalid = 1'b0;
        mosi.wlast  = 1'b0;
    endtask

    task automatic axi_read(input axi_id_t id, input axi_addr_t addr, input logic [7:0] len,
                            input logic [2:0] size, input axi_burst_t burst);
        bit ok;
        @(posedge clk); #1;
        mosi.arid = id; mosi.araddr = addr; mosi.arlen = len; mosi.arsize = size;
        mosi.arburst = burst; mosi.arprot = 3'b000; mosi.arvalid = 1'b1;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (miso.arready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        mosi.arvalid = 1'b0;
        if (!ok) timeout("axi_ar");
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (exp_aw_q.size() == 0 && exp_w_q.size() == 0 && exp_ar_q.size() == 0 &&
                exp_b_q.size() == 0 && exp_r_q.size() == 0)
                return;
        end
        timeout(name);
        exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
        exp_b_q.delete(); exp_r_q.delete(); slv_bresp_q.delete();
    endtask

    task automatic report();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        timeout("watchdog");
        report();
        $finish;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int base_n;
        bit ok;
        mosi = '0;
        mosi.bready = 1'b1;
        mosi.rready = 1'b1;
        mosi.wstrb  = '1;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_awready", miso.awready, 0);
        check("rst_arready", miso.arready, 0);
        check("rst_axil_awvalid", lmosi.awvalid, 0);
        check("rst_axil_wvalid", lmosi.wvalid, 0);
        check("rst_axil_arvalid", lmosi.arvalid, 0);
        check("rst_axil_bready", lmosi.bready, 0);
        check("rst_axil_rready", lmosi.rready, 0);
        check("rst_bvalid", miso.bvalid, 0);
        check("rst_rvalid", miso.rvalid, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_awready", miso.awready, 1);
        check("post_rst_arready", miso.arready, 1);

        // INCR write, 4 beats of 4 bytes.
        exp_aw(4'h3, 32'h1000); exp_aw(4'h3, 32'h1004); exp_aw(4'h3, 32'h1008); exp_aw(4'h3, 32'h100C);
        exp_w_q.push_back(32'h1111_0000); exp_w_q.push_back(32'h1111_0001);
        exp_w_q.push_back(32'h1111_0002); exp_w_q.push_back(32'h1111_0003);
        exp_b(4'h3, AXI_RESP_OKAY);
        axi_write(4'h3, 32'h1000, 8'd3, 3'd2, AXI_BURST_INCR, 32'h1111_0000);
        wait_drain("incr_write");

        // WRAP read, 16-byte window starting mid-window.
        exp_ar(4'h7, 32'h2008); exp_ar(4'h7, 32'h200C); exp_ar(4'h7, 32'h2000); exp_ar(4'h7, 32'h2004);
        exp_r(4'h7, 32'hA5A5_2008, 1'b0); exp_r(4'h7, 32'hA5A5_200C, 1'b0);
        exp_r(4'h7, 32'hA5A5_2000, 1'b0); exp_r(4'h7, 32'hA5A5_2004, 1'b1);
        axi_read(4'h7, 32'h2008, 8'd3, 3'd2, AXI_BURST_WRAP);
        wait_drain("wrap_read");

        // Error merge: SLVERR on the middle beat survives a later OKAY.
        slv_bresp_q.push_back(AXI_RESP_OKAY);
        slv_bresp_q.push_back(AXI_RESP_SLVERR);
        slv_bresp_q.push_back(AXI_RESP_OKAY);
        exp_aw(4'h2, 32'h6000); exp_aw(4'h2, 32'h6004); exp_aw(4'h2, 32'h6008);
        exp_w_q.push_back(32'h2222_0000); exp_w_q.push_back(32'h2222_0001); exp_w_q.push_back(32'h2222_0002);
        exp_b(4'h2, AXI_RESP_SLVERR);
        axi_write(4'h2, 32'h6000, 8'd2, 3'd2, AXI_BURST_INCR, 32'h2222_0000);
        wait_drain("slverr_merge");

        // DECERR outranks a later SLVERR; 8-byte steps.
        slv_bresp_q.push_back(AXI_RESP_DECERR);
        slv_bresp_q.push_back(AXI_RESP_SLVERR);
        exp_aw(4'h4, 32'h7000); exp_aw(4'h4, 32'h7008);
        exp_w_q.push_back(32'h4444_0000); exp_w_q.push_back(32'h4444_0001);
        exp_b(4'h4, AXI_RESP_DECERR);
        axi_write(4'h4, 32'h7000, 8'd1, 3'd3, AXI_BURST_INCR, 32'h4444_0000);
        wait_drain("decerr_merge");

        // Concurrent write and read with 5 cycles of response backpressure.
        mosi.bready = 1'b0;
        mosi.rready = 1'b0;
        exp_aw(4'h5, 32'h4000); exp_aw(4'h5, 32'h4004);
        exp_w_q.push_back(32'h5555_0000); exp_w_q.push_back(32'h5555_0001);
        exp_b(4'h5, AXI_RESP_OKAY);
        exp_ar(4'h6, 32'h5000); exp_ar(4'h6, 32'h5004);
        exp_r(4'h6, 32'hA5A5_5000, 1'b0); exp_r(4'h6, 32'hA5A5_5004, 1'b1);
        fork
            axi_write(4'h5, 32'h4000, 8'd1, 3'd2, AXI_BURST_INCR, 32'h5555_0000);
            axi_read(4'h6, 32'h5000, 8'd1, 3'd2, AXI_BURST_INCR);
            begin
                repeat (5) @(posedge clk);
                #1;
                mosi.bready = 1'b1;
                mosi.rready = 1'b1;
            end
        join
        wait_drain("concurrent");

        // FIXED read: every beat at the same address.
        exp_ar(4'h1, 32'h3000); exp_ar(4'h1, 32'h3000); exp_ar(4'h1, 32'h3000);
        exp_r(4'h1, 32'hA5A5_3000, 1'b0); exp_r(4'h1, 32'hA5A5_3000, 1'b0); exp_r(4'h1, 32'hA5A5_3000, 1'b1);
        axi_read(4'h1, 32'h3000, 8'd2, 3'd2, AXI_BURST_FIXED);
        wait_drain("fixed_read");

        // Reserved burst code behaves as INCR (2-byte steps).
        exp_ar(4'h9, 32'h8000); exp_ar(4'h9, 32'h8002);
        exp_r(4'h9, 32'hA5A5_8000, 1'b0); exp_r(4'h9, 32'hA5A5_8002, 1'b1);
        axi_read(4'h9, 32'h8000, 8'd1, 3'd1, AXI_BURST_RSVD);
        wait_drain("rsvd_read");

        // 256-beat byte read: counter must reach 255 for rlast.
        for (int i = 0; i < 256; i++) begin
            exp_ar(4'hA, 32'h9000 + 32'(i));
            exp_r(4'hA, (32'h9000 + 32'(i)) ^ 32'hA5A5_0000, i == 255);
        end
        axi_read(4'hA, 32'h9000, 8'd255, 3'd0, AXI_BURST_INCR);
        wait_drain("len256_read");

        // Reset during beat 2 of an 8-beat write.
        for (int i = 0; i < 8; i++) begin
            exp_aw(4'h8, 32'hA000 + 32'(4 * i));
            exp_w_q.push_back(32'hDEAD_0000);
        end
        base_n = mon_aw_n;
        @(posedge clk); #1;
        mosi.awid = 4'h8; mosi.awaddr = 32'hA000; mosi.awlen = 8'd7; mosi.awsize = 3'd2;
        mosi.awburst = AXI_BURST_INCR; mosi.awvalid = 1'b1;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (miso.awready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        mosi.awvalid = 1'b0;
        mosi.wvalid  = 1'b1;
        mosi.wdata   = 32'hDEAD_0000;
        if (!ok) timeout("rst_aw");
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            if (mon_aw_n >= base_n + 2) begin ok = 1; break; end
        end
        if (!ok) timeout("rst_beat2");
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_axil_awvalid", lmosi.awvalid, 0);
        check("midrst_axil_wvalid", lmosi.wvalid, 0);
        check("midrst_axil_bready", lmosi.bready, 0);
        check("midrst_axil_arvalid", lmosi.arvalid, 0);
        check("midrst_axil_rready", lmosi.rready, 0);
        check("midrst_bvalid", miso.bvalid, 0);
        check("midrst_rvalid", miso.rvalid, 0);
        check("midrst_awready", miso.awready, 0);
        mosi.wvalid = 1'b0;
        exp_aw_q.delete(); exp_w_q.delete(); exp_b_q.delete(); slv_bresp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rerst_awready", miso.awready, 1);
        check("rerst_arready", miso.arready, 1);

        // Fresh single-beat write after the aborted burst.
        exp_aw(4'hB, 32'hC000);
        exp_w_q.push_back(32'hBBBB_0000);
        exp_b(4'hB, AXI_RESP_OKAY);
        axi_write(4'hB, 32'hC000, 8'd0, 3'd2, AXI_BURST_INCR, 32'hBBBB_0000);
        wait_drain("post_reset_write");

        repeat (5) @(negedge clk);
        check("leftover_expectations",
              exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_b_q.size() + exp_r_q.size(), 0);
        report();
        $finish;
    end

endmodule

// File: doc/axi_burst_to_axil.md
AXI_BURST_TO_AXIL -- requirements
Module: axi_burst_to_axil

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port axi_mosi_i, input, s_axi_mosi_t, full-AXI slave-side requests: AW, W, AR, bready, rready.
REQ-004 SHALL have port axi_miso_o, output, s_axi_miso_t, full-AXI slave-side responses.
REQ-005 SHALL have port axil_mosi_o, output, s_axil_mosi_t, AXI-Lite master-side requests toward the downstream slave.
REQ-006 SHALL have no parameters; all widths come from amba_axi_pkg.

Function
REQ-007 SHALL split each full-AXI burst into awlen+1 or arlen+1 single AXI-Lite transactions, issued strictly one at a time.
REQ-008 SHALL run the write and read paths as independent FSMs that may be active simultaneously.
REQ-009 Write FSM states: W_IDLE, W_BEAT, W_BRESP, W_DONE.
REQ-010 In W_IDLE, axi awready SHALL be 1; on the AW handshake, the block SHALL capture awid, awaddr, awlen, awsize, awburst and awprot, clear the beat counter and the response accumulator, and go to W_BEAT.
REQ-011 In W_BEAT, the block SHALL drive AXI-Lite awvalid with the current address and pass wvalid/wdata/wstrb through, with axi wready = axil wready; aw_done and w_done flags SHALL track each handshake independently, and both done SHALL move the FSM to W_BRESP.
REQ-012 In W_BRESP, the block SHALL drive axil bready=1; on axil bvalid it SHALL merge bresp into the accumulator (numerically larger code wins: DECERR>SLVERR>OKAY).
- if the beat counter equals awlen: go to W_DONE.
- otherwise: advance the address, increment the counter and return to W_BEAT.
REQ-013 In W_DONE, the block SHALL drive axi bvalid=1 with bid=captured awid and bresp=accumulator, holding both stable until bready; it SHALL then return to W_IDLE.
REQ-014 The block SHALL never accept W data outside W_BEAT: axi wready=0.
REQ-015 Read FSM states: R_IDLE, R_ADDR, R_DATA.
REQ-016 In R_IDLE, arready SHALL be 1; on the AR handshake, the block SHALL capture the AR fields and go to R_ADDR.
REQ-017 In R_ADDR, the block SHALL drive axil arvalid; on arready it SHALL go to R_DATA.
REQ-018 In R_DATA, the block SHALL pass through axi rvalid=axil rvalid, rdata, rresp and axil rready=axi rready, with rid=captured arid and rlast=(counter==arlen).
REQ-019 On the R handshake in R_DATA:
- last beat: go to R_IDLE.
- otherwise: advance the address, increment the counter and go to R_ADDR.
REQ-020 Address advance SHALL depend on the burst type, with step=1<<size:
- FIXED: the address SHALL be unchanged.
- INCR: the address SHALL be addr+step, truncated to the address width.
- WRAP: the address SHALL be incremented within the aligned boundary of (len+1)*step, wrapping to the boundary base.
- Reserved 2'b11: the address SHALL be treated as INCR.
REQ-021 The beat counter SHALL be 8 bits wide, so 256-beat bursts SHALL be supported.
REQ-022 Latency:
- AW handshake to the first axil awvalid: 1 cycle.
- Last axil B handshake to axi bvalid: 1 cycle.
- AR handshake to axil arvalid: 1 cycle.
REQ-023 The block SHALL drive axil awid/arid from the captured IDs, and SHALL drive buser/ruser to 0.

Reset
REQ-024 While rst=0, both FSMs SHALL be forced to IDLE, and all counters, flags and captured fields SHALL be forced to 0.
REQ-025 While rst=0, all valid outputs and axil bready/rready SHALL be 0.
REQ-026 While rst=0, axi awready and arready SHALL be 0; they SHALL be 1 from the first cycle after rst rises.
REQ-027 Reset mid-burst SHALL abort immediately with no further beats or responses; the downstream transaction is abandoned.

Structure
REQ-028 The FSM state enums SHALL live in amba_axi_pkg as axi2axil_wr_st_t and axi2axil_rd_st_t; the existing burst and response typedefs SHALL be reused from the same package.
REQ-029 The next-address computation SHALL be a combinational sub-module, axi_addr_gen (inputs addr, size, len, burst; output next_addr), instantiated once per path.
REQ-030 Total RTL SHALL be about 250 lines.

Verification
REQ-031 INCR write: AW addr=0x1000, len=3, size=2 -> 4 axil writes at 0x1000, 0x1004, 0x1008, 0x100C; one axi B with bid=awid, bresp=OKAY.
REQ-032 WRAP read: addr=0x2008, len=3, size=2 -> axil reads at 0x2008, 0x200C, 0x2000, 0x2004; rlast=1 only on the 4th beat.
REQ-033 Error merge: 3-beat write whose beat 2 gets SLVERR and others OKAY -> single axi bresp=SLVERR after the 3rd beat.
REQ-034 Concurrency and backpressure:
- Stimulus: write len=1 and read len=1 issued in the same cycle; rready and bready held low for 5 cycles.
- Response: both complete, no data loss, rdata order preserved.
REQ-035 FIXED: read addr=0x3000, len=2 -> three axil reads, all at 0x3000.
REQ-036 Reset mid-burst: rst low during beat 2 of an 8-beat write -> all valids 0 next edge; after release a fresh len=0 write completes normally.
